mult_share_ctrl: RTL and testbench

//  Sequencer/arbiter sharing one MultU4Bits (unsigned 4x4->8) between two requesters, A and B.

---
 rtl/mult_share_pkg.sv | 18 +
 rtl/MultU4Bits.sv | 10 +
 rtl/mult_rr_arb2.sv | 33 +++
 rtl/mult_share_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mult_share_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the mult_share_ctrl sequencer/arbiter.
package mult_share_pkg;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MULT,
        SIGN,
        DONE
    } state_t;

endpackage

// File: rtl/MultU4Bits.sv
// Existing shared datapath: unsigned 4x4 -> 8 combinational multiplier.
module MultU4Bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = 8'(a) * 8'(b);

endmodule

// File: rtl/mult_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module mult_rr_arb2
    import mult_share_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == ID_A) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_B;
        end else if (en && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one MultU4Bits between requesters A and B; signed ops use sign-magnitude.
// Optional MULT_ZERO_SKIP_EN: zero-magnitude operands bypass the multiplier (LOAD -> DONE).
module mult_share_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [WIDTH-1:0]   a_x,
    input  logic [WIDTH-1:0]   a_y,
    input  logic               a_signed,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [WIDTH-1:0]   b_x,
    input  logic [WIDTH-1:0]   b_y,
    input  logic               b_signed,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_prod,
    output logic               res_id
);
    import mult_share_pkg::*;

    localparam int unsigned PW = 2 * WIDTH;

    if (WIDTH != 4) begin : g_width_chk
        $error("mult_share_ctrl: WIDTH must be 4 to match MultU4Bits");
    end

    state_t           state, state_nxt;
    logic [1:0]       req, grant;
    logic             hs, sel_b;
    logic [WIDTH-1:0] op_x, op_y, mag_x, mag_y, mag_x_c, mag_y_c;
    logic             op_sgn, op_id, neg, neg_c;
    logic [PW-1:0]    mult_p, p_q, prod_c;
    logic             res_valid_nxt, res_id_nxt;
    logic [PW-1:0]    res_prod_nxt;

    assign req     = {b_valid, a_valid};
    assign hs      = (state == IDLE) && (req != 2'b00);
    assign sel_b   = grant[1];
    assign a_ready = (state == IDLE) && grant[0];
    assign b_ready = (state == IDLE) && grant[1];

    mult_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .en    (hs),
        .grant (grant)
    );

    MultU4Bits u_mult (
        .a (mag_x),
        .b (mag_y),
        .p (mult_p)
    );

    // Sign-magnitude split of the latched operands; -8 maps to magnitude 8.
    always_comb begin
        mag_x_c = op_x;
        mag_y_c = op_y;
        neg_c   = 1'b0;
        if (op_sgn) begin
            if (op_x[WIDTH-1]) mag_x_c = WIDTH'(~op_x + 1'b1);
            if (op_y[WIDTH-1]) mag_y_c = WIDTH'(~op_y + 1'b1);
            neg_c = op_x[WIDTH-1] ^ op_y[WIDTH-1];
        end
    end

    assign prod_c = neg ? PW'(~p_q + 1'b1) : p_q;

`ifdef MULT_ZERO_SKIP_EN
    logic zero_c;
    assign zero_c = (mag_x_c == '0) || (mag_y_c == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hs) state_nxt = LOAD;
`ifdef MULT_ZERO_SKIP_EN
            LOAD: state_nxt = zero_c ? DONE : MULT;
`else
            LOAD: state_nxt = MULT;
`endif
            MULT: state_nxt = SIGN;
            SIGN: state_nxt = DONE;
            DONE: if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered result port; held unless a result is produced.
    always_comb begin
        res_valid_nxt = (state_nxt == DONE);
        res_prod_nxt  = res_prod;
        res_id_nxt    = res_id;
        case (state)
`ifdef MULT_ZERO_SKIP_EN
            LOAD: if (zero_c) begin
                res_prod_nxt = '0;
                res_id_nxt   = op_id;
            end
`endif
            SIGN: begin
                res_prod_nxt = prod_c;
                res_id_nxt   = op_id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_prod  <= '0;
            res_id    <= ID_A;
        end else begin
            res_valid <= res_valid_nxt;
            res_prod  <= res_prod_nxt;
            res_id    <= res_id_nxt;
        end
    end

    // Operand latch, magnitude stage and multiplier output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_x   <= '0;
            op_y   <= '0;
            op_sgn <= 1'b0;
            op_id  <= ID_A;
            mag_x  <= '0;
            mag_y  <= '0;
            neg    <= 1'b0;
            p_q    <= '0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    op_x   <= sel_b ? b_x : a_x;
                    op_y   <= sel_b ? b_y : a_y;
                    op_sgn <= sel_b ? b_signed : a_signed;
                    op_id  <= sel_b;
                end
                LOAD: begin
                    mag_x <= mag_x_c;
                    mag_y <= mag_y_c;
                    neg   <= neg_c;
                end
                MULT: p_q <= mult_p;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: latency, signed edges, alternation, backpressure, reset.
module tb_mult_share_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, a_ready, a_signed;
    logic [3:0] a_x, a_y;
    logic       b_valid, b_ready, b_signed;
    logic [3:0] b_x, b_y;
    logic       res_valid, res_ready, res_id;
    logic [7:0] res_prod;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] ta_x [3], ta_y [3], tb_x [3], tb_y [3];
    logic       ta_s [3], tb_s [3];
    logic [7:0] ta_p [3], tb_p [3];

    always #5 clk = ~clk;

    mult_share_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_x       (a_x),
        .a_y       (a_y),
        .a_signed  (a_signed),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_x       (b_x),
        .b_y       (b_y),
        .b_signed  (b_signed),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_prod  (res_prod),
        .res_id    (res_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, measure latency from handshake, check the result and its retirement.
    task automatic run_op(input string tag, input bit id, input logic [3:0] x, input logic [3:0] y,
                          input bit sgn, input logic [7:0] exp_p, input int exp_lat);
        bit got;
        int lat;
        @(negedge clk);
        res_ready = 1'b1;
        if (id) begin b_valid = 1'b1; b_x = x; b_y = y; b_signed = sgn; end
        else    begin a_valid = 1'b1; a_x = x; a_y = y; a_signed = sgn; end
        #1;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (id ? b_ready : a_ready) begin got = 1'b1; break; end
            @(negedge clk); #1;
        end
        chk({tag, "_hs"}, 32'(got), 1);
        if (!got) begin
            a_valid = 1'b0; b_valid = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
        chk({tag, "_prod"}, 32'(res_prod), 32'(exp_p));
        chk({tag, "_id"},   32'(res_id), 32'(id));
        @(posedge clk); @(negedge clk);
        chk({tag, "_clr"},  32'(res_valid), 0);
    endtask

    task automatic set_a(input int i);
        a_x = ta_x[i]; a_y = ta_y[i]; a_signed = ta_s[i];
    endtask

    task automatic set_b(input int i);
        b_x = tb_x[i]; b_y = tb_y[i]; b_signed = tb_s[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int  zlat, cnt, lat, ai, bi, nres, ngr;
        bit  pa, pb, got;
        logic [7:0] expq [$];
        logic [7:0] ep;

        // Alternation tables (hand-computed products)
        ta_x[0] = 4'h1; ta_y[0] = 4'h2; ta_s[0] = 1'b0; ta_p[0] = 8'h02;
        ta_x[1] = 4'hF; ta_y[1] = 4'hF; ta_s[1] = 1'b1; ta_p[1] = 8'h01;
        ta_x[2] = 4'h6; ta_y[2] = 4'hB; ta_s[2] = 1'b1; ta_p[2] = 8'hE2;
        tb_x[0] = 4'h3; tb_y[0] = 4'h3; tb_s[0] = 1'b0; tb_p[0] = 8'h09;
        tb_x[1] = 4'hE; tb_y[1] = 4'h5; tb_s[1] = 1'b1; tb_p[1] = 8'hF6;
        tb_x[2] = 4'hC; tb_y[2] = 4'h4; tb_s[2] = 1'b0; tb_p[2] = 8'h30;

`ifdef MULT_ZERO_SKIP_EN
        zlat = 2;
`else
        zlat = 4;
`endif

        rst_n = 1'b0; res_ready = 1'b1;
        a_valid = 1'b0; a_x = '0; a_y = '0; a_signed = 1'b0;
        b_valid = 1'b0; b_x = '0; b_y = '0; b_signed = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_prod",  32'(res_prod), 0);
        chk("rst_res_id",    32'(res_id), 0);
        chk("rst_ready",     32'({a_ready, b_ready}), 0);
        rst_n = 1'b1;

        run_op("a_m3x5",   1'b0, 4'hD, 4'h5, 1'b1, 8'hF1, 4);
        run_op("b_u15x15", 1'b1, 4'hF, 4'hF, 1'b0, 8'hE1, 4);
        run_op("b_sm8xm8", 1'b1, 4'h8, 4'h8, 1'b1, 8'h40, 4);
        run_op("b_sm8x7",  1'b1, 4'h8, 4'h7, 1'b1, 8'hC8, 4);
        run_op("a_u7x9",   1'b0, 4'h7, 4'h9, 1'b0, 8'h3F, 4);
        run_op("b_s7xm1",  1'b1, 4'h7, 4'hF, 1'b1, 8'hF9, 4);
        run_op("a_s0xm5",  1'b0, 4'h0, 4'hB, 1'b1, 8'h00, zlat);
        run_op("b_u3x0",   1'b1, 4'h3, 4'h0, 1'b0, 8'h00, zlat);

        // Backpressure: B signed -7*6 held in DONE while both requesters push
        @(negedge clk);
        res_ready = 1'b0;
        b_valid = 1'b1; b_x = 4'h9; b_y = 4'h6; b_signed = 1'b1;
        #1;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (b_ready) begin got = 1'b1; break; end
            @(negedge clk); #1;
        end
        chk("bp_hs", 32'(got), 1);
        @(posedge clk); @(negedge clk);
        a_valid = 1'b1; a_x = 4'h2; a_y = 4'h2; a_signed = 1'b0;
        b_x = 4'h5; b_y = 4'h5; b_signed = 1'b0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk("bp_lat", 32'(lat), 4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_prod",  32'(res_prod), 'hD6);
            chk("bp_id",    32'(res_id), 1);
            chk("bp_a_rdy", 32'(a_ready), 0);
            chk("bp_b_rdy", 32'(b_ready), 0);
        end

        // Reset while a result is being held
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstdone_valid", 32'(res_valid), 0);
        chk("rstdone_prod",  32'(res_prod), 0);
        chk("rstdone_id",    32'(res_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;

        // Reset while the op is in MULT
        @(negedge clk);
        a_valid = 1'b1; a_x = 4'h5; a_y = 4'h3; a_signed = 1'b0;
        #1;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (a_ready) begin got = 1'b1; break; end
            @(negedge clk); #1;
        end
        chk("rstmul_hs", 32'(got), 1);
        @(posedge clk); @(negedge clk);
        a_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmul_valid", 32'(res_valid), 0);
        chk("rstmul_prod",  32'(res_prod), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        chk("rstmul_stale", 32'(cnt), 0);

        // Both requesters valid every cycle: expect A,B,A,B,A,B
        @(negedge clk);
        ai = 0; bi = 0; nres = 0; ngr = 0; pa = 1'b0; pb = 1'b0;
        set_a(0); set_b(0);
        a_valid = 1'b1; b_valid = 1'b1;
        for (int c = 0; c < 200 && nres < 6; c++) begin
            if (c != 0) @(negedge clk);
            if (pa) begin
                ai++;
                if (ai < 3) set_a(ai); else a_valid = 1'b0;
            end
            if (pb) begin
                bi++;
                if (bi < 3) set_b(bi); else b_valid = 1'b0;
            end
            pa = 1'b0; pb = 1'b0;
            #1;
            if (res_valid) begin
                chk("alt_res_id", 32'(res_id), 32'(nres % 2));
                if (expq.size() != 0) begin
                    ep = expq.pop_front();
                    chk("alt_res_prod", 32'(res_prod), 32'(ep));
                end else begin
                    chk("alt_res_unexpected", 32'(res_valid), 0);
                end
                nres++;
            end
            if (a_ready || b_ready) begin
                chk("alt_grant", 32'(b_ready), 32'(ngr % 2));
                chk("alt_onehot", 32'(a_ready & b_ready), 0);
                if (a_ready) begin pa = 1'b1; expq.push_back(ta_p[ai]); end
                else         begin pb = 1'b1; expq.push_back(tb_p[bi]); end
                ngr++;
            end
        end
        chk("alt_nres", 32'(nres), 6);
        @(negedge clk);
        if (pa) begin ai++; a_valid = 1'b0; end
        if (pb) begin bi++; b_valid = 1'b0; end
        chk("alt_a_ops", 32'(ai), 3);
        chk("alt_b_ops", 32'(bi), 3);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        chk("alt_no_extra", 32'(cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
